game_match_fsm: RTL

Parametrised match controller for the tank/shooter game. It generalises the two-player menu/play/continue/final flow to NUM_PLAYERS players, with a selectable target score, last-survivor round scoring, and a timed round-end hold. It sits between the keyboard/collision logic and the renderer and drives per-player scores, screen-select flags, and the playfield reset.

---
 rtl/game_match_fsm.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/game_match_fsm.sv
// game_match_fsm: match controller for the tank/shooter game.
// Runs the MENU -> PLAYING -> ROUND_END -> CONTINUE/FINAL flow for NUM_PLAYERS
// players. It handles target score selection, last-survivor round scoring and
// a timed round-end hold. Every output comes straight from a flop.
// Optional feature: define GAME_MATCH_TIMEOUT_EN to end a round as a draw
// after ROUND_TIMEOUT PLAYING cycles.
module game_match_fsm #(
  parameter int unsigned     NUM_PLAYERS   = 2,
  parameter int unsigned     SCORE_W       = 6,
  parameter int unsigned     MAX_TARGET    = 9,
  parameter int unsigned     HOLD_CYCLES   = 50_000_000,
  parameter longint unsigned ROUND_TIMEOUT = 64'd3_000_000_000
) (
  input  logic                           clk_i,
  input  logic                           reset_ni,
  input  logic                           space_i,
  input  logic                           select_up_i,
  input  logic                           select_down_i,
  input  logic [NUM_PLAYERS-1:0]         hit_i,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score_o,
  output logic [SCORE_W-1:0]             target_o,
  output logic [NUM_PLAYERS-1:0]         alive_o,
  output logic [2:0]                     winner_o,
  output logic                           winner_valid_o,
  output logic                           is_menu_o,
  output logic                           is_playing_o,
  output logic                           is_round_end_o,
  output logic                           is_continue_o,
  output logic                           is_final_o,
  output logic                           reset_o
);

  typedef enum logic [2:0] {
    S_MENU      = 3'd0,
    S_PLAYING   = 3'd1,
    S_ROUND_END = 3'd2,
    S_CONTINUE  = 3'd3,
    S_FINAL     = 3'd4
  } state_t;

  localparam int unsigned        CNT_W      = $clog2(NUM_PLAYERS + 1);
  localparam int unsigned        HOLD_W     = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [SCORE_W-1:0] TARGET_MAX = SCORE_W'(MAX_TARGET);
  localparam logic [SCORE_W-1:0] TARGET_RST = (MAX_TARGET < 3) ? SCORE_W'(MAX_TARGET) : SCORE_W'(3);

  state_t                              state_q, state_d;
  logic                                armed_q;
  logic                                space_q, up_q, down_q;
  logic [NUM_PLAYERS-1:0]              hit_q;
  logic                                space_p, up_p, down_p;
  logic [NUM_PLAYERS-1:0]              hit_p;
  logic [NUM_PLAYERS-1:0][SCORE_W-1:0] score_q, score_d;
  logic [SCORE_W-1:0]                  target_d;
  logic [NUM_PLAYERS-1:0]              alive_d, alive_hit;
  logic [2:0]                          winner_d, survivor;
  logic                                winner_valid_d;
  logic [HOLD_W-1:0]                   hold_q, hold_d;
  logic                                hold_done, round_over, match_won, timed_out;
  logic [CNT_W-1:0]                    alive_cnt;

  // armed_q masks the first edge after reset so a level held across release is
  // captured into history instead of being seen as a fresh press.
  assign space_p = armed_q & space_i & ~space_q;
  assign up_p    = armed_q & select_up_i & ~up_q;
  assign down_p  = armed_q & select_down_i & ~down_q;
  assign hit_p   = armed_q ? (hit_i & ~hit_q) : '0;

  assign score_o   = score_q;
  assign alive_hit = alive_o & ~hit_p;
  assign hold_done = (hold_q == HOLD_W'(HOLD_CYCLES - 1));

  function automatic logic [CNT_W-1:0] popcount(input logic [NUM_PLAYERS-1:0] v);
    popcount = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) popcount = popcount + CNT_W'(v[i]);
  endfunction

  assign alive_cnt  = popcount(alive_hit);
  assign round_over = (state_q == S_PLAYING) && (alive_cnt <= CNT_W'(1));

  // Index of the surviving player (meaningful only when exactly one is alive).
  always_comb begin
    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    survivor = '0;
    for (int i = 0; i < NUM_PLAYERS; i++) if (alive_hit[i]) survivor = 3'(i);
  end

  // Match is over once any player has reached the target.
  always_comb begin
    match_won = 1'b0;
    for (int i = 0; i < NUM_PLAYERS; i++) if (score_q[i] >= target_o) match_won = 1'b1;
  end

`ifdef GAME_MATCH_TIMEOUT_EN
  localparam int unsigned RT_W = (ROUND_TIMEOUT > 64'd1) ? $clog2(ROUND_TIMEOUT) : 1;
  logic [RT_W-1:0] round_cnt_q;

  assign timed_out = (state_q == S_PLAYING) && (round_cnt_q == RT_W'(ROUND_TIMEOUT - 1));

  // Round timer: counts consecutive PLAYING cycles and clears outside them.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni)                                      round_cnt_q <= '0;
    else if (state_q == S_PLAYING && state_d == S_PLAYING) round_cnt_q <= round_cnt_q + 1'b1;
    else                                                round_cnt_q <= '0;
  end
`else
  assign timed_out = 1'b0;
`endif

  // State register plus every registered output and edge-detector history.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= S_MENU;
      armed_q        <= 1'b0;
      space_q        <= 1'b0;
      up_q           <= 1'b0;
      down_q         <= 1'b0;
      hit_q          <= '0;
      score_q        <= '0;
      target_o       <= TARGET_RST;
      alive_o        <= '1;
      winner_o       <= '0;
      winner_valid_o <= 1'b0;
      hold_q         <= '0;
      is_menu_o      <= 1'b1;
      is_playing_o   <= 1'b0;
      is_round_end_o <= 1'b0;
      is_continue_o  <= 1'b0;
      is_final_o     <= 1'b0;
      reset_o        <= 1'b1;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops sample together.
      state_q        <= state_d;
      armed_q        <= 1'b1;
      space_q        <= space_i;
      up_q           <= select_up_i;
      down_q         <= select_down_i;
      hit_q          <= hit_i;
      score_q        <= score_d;
      target_o       <= target_d;
      alive_o        <= alive_d;
      winner_o       <= winner_d;
      winner_valid_o <= winner_valid_d;
      hold_q         <= hold_d;
      is_menu_o      <= (state_d == S_MENU);
      is_playing_o   <= (state_d == S_PLAYING);
      is_round_end_o <= (state_d == S_ROUND_END);
      is_continue_o  <= (state_d == S_CONTINUE);
      is_final_o     <= (state_d == S_FINAL);
      reset_o        <= (state_d != S_PLAYING);
    end
  end

  // Next-state selection; illegal encodings fall back to MENU.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_MENU:      if (space_p) state_d = S_PLAYING;
      S_PLAYING:   if (round_over || timed_out) state_d = S_ROUND_END;
      S_ROUND_END: if (hold_done) state_d = match_won ? S_FINAL : S_CONTINUE;
      S_CONTINUE:  if (space_p) state_d = S_PLAYING;
      S_FINAL:     if (space_p) state_d = S_MENU;
      default:     state_d = S_MENU;
    endcase
  end

  // Next values of the datapath outputs (scores, target, alive, winner, hold).
  always_comb begin
    score_d        = score_q;
    target_d       = target_o;
    alive_d        = alive_o;
    winner_d       = winner_o;
    winner_valid_d = winner_valid_o;
    hold_d         = (state_q == S_ROUND_END && !hold_done) ? hold_q + 1'b1 : '0;
    case (state_q)
      S_MENU: begin
        if (up_p && !down_p && target_o < TARGET_MAX)      target_d = target_o + 1'b1;
        else if (down_p && !up_p && target_o > SCORE_W'(1)) target_d = target_o - 1'b1;
        if (space_p) begin
          score_d        = '0;
          alive_d        = '1;
          winner_d       = '0;
          winner_valid_d = 1'b0;
        end
      end
      S_PLAYING: begin
        alive_d = alive_hit;
        if (round_over) begin
          if (alive_cnt == CNT_W'(1)) begin
            for (int i = 0; i < NUM_PLAYERS; i++)
              if (alive_hit[i] && !(&score_q[i])) score_d[i] = score_q[i] + 1'b1;
            winner_d       = survivor;
            winner_valid_d = 1'b1;
          end else begin
            winner_valid_d = 1'b0;
          end
        end else if (timed_out) begin
          winner_valid_d = 1'b0;
        end
      end
      S_CONTINUE: if (space_p) alive_d = '1;
      default: ;
    endcase
  end

endmodule
